// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetches 16-bit words from a 16-entry program
// store, stages ALU operands from a 4x8 register file and writes back the ALU result.
module cpu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [7:0]  reg_data,
  input  logic        start,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [2:0]  opcode,
  output logic        save,
  input  logic [7:0]  alu_out,
  input  logic        carry_out,
  output logic        busy,
  output logic        done,
  output logic [3:0]  pc,
  output logic        carry_flag,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]  state;
  logic [15:0] mem  [16];
  logic [7:0]  regs [4];
  logic [15:0] ir;

  logic [2:0] ir_op;
  logic [1:0] ir_ra, ir_rb, ir_rd;
  logic       ir_save, ir_halt;
  logic [4:0] ir_rsvd;

  assign ir_op   = ir[15:13];
  assign ir_ra   = ir[12:11];
  assign ir_rb   = ir[10:9];
  assign ir_rd   = ir[8:7];
  assign ir_save = ir[6];
  assign ir_halt = ir[5];
  assign ir_rsvd = ir[4:0];

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      opcode     <= '0;
      save       <= 1'b0;
      pc         <= '0;
      carry_flag <= 1'b0;
      ir         <= '0;
      for (int i = 0; i < 4; i++)  regs[i] <= '0;
      for (int i = 0; i < 16; i++) mem[i]  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Loads and start may share an edge; both take effect.
          if (prog_we) mem[prog_addr] <= prog_data;
          if (reg_we)  regs[reg_addr] <= reg_data;
          if (start) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          ir    <= mem[pc];
          state <= DECODE;
        end
        DECODE: begin
          a      <= regs[ir_ra];
          b      <= regs[ir_rb];
          opcode <= ir_op;
          state  <= EXEC;
        end
        EXEC: begin
          save  <= ir_save;
          state <= WB;
        end
        WB: begin
          regs[ir_rd] <= alu_out;
          carry_flag  <= carry_out;
          save        <= 1'b0;
          if (ir_halt) begin
            state <= DONE;
          end else begin
            // pc wraps 15 -> 0 naturally; programs without a halt loop forever.
            pc    <= pc + 4'd1;
            state <= FETCH;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Low word bits are reserved and intentionally ignored.
  logic rsvd_unused;
  assign rsvd_unused = ^ir_rsvd;

endmodule
